// File: rtl/uart_tx_req_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ debounced
// requesters: latches request pulses, grants in rotating order, start/busy handshake.
module uart_tx_req_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BUSY_TO = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [N_REQ-1:0]          req_pulse,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic [N_REQ-1:0]          pend,
  output logic [N_REQ-1:0]          ovf,
  output logic                      hs_err,
  input  logic                      err_clr
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BUSY_TO) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TO - 1);
  localparam logic [IW-1:0] GID_RST  = IW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     sel, idx;
  logic              grant, hs_set;
  logic [N_REQ-1:0]  grant_vec;

  // Walk offsets from farthest to nearest so the nearest pending index wins.
  always_comb begin
    sel = grant_id;
    idx = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      idx = IW'((32'(grant_id) + k) % N_REQ);
      if (pend[idx]) sel = idx;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant   = 1'b0;
    hs_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend != '0 && !tx_busy) begin
          grant   = 1'b1;
          cnt_n   = '0;
          state_n = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          hs_set  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign grant_vec = grant ? (N_REQ'(1) << sel) : '0;

  // A pulse coinciding with its own grant re-queues rather than overflowing.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= GID_RST;
      pend     <= '0;
      ovf      <= '0;
      hs_err   <= 1'b0;
    end else begin
      tx_start <= grant;
      if (grant) begin
        tx_data  <= req_data[sel*DATA_W +: DATA_W];
        grant_id <= sel;
      end
      pend   <= (pend & ~grant_vec) | req_pulse;
      ovf    <= (err_clr ? '0 : ovf) | (req_pulse & pend & ~grant_vec);
      hs_err <= (hs_err & ~err_clr) | hs_set;
    end
  end

endmodule

// File: tb/tb_uart_tx_req_sched.sv
// Bench for uart_tx_req_sched: directed scenarios plus randomized traffic
// against a transaction-phase reference model.
module tb_uart_tx_req_sched;

  localparam int N = 4;
  localparam int W = 8;
  localparam int TO = 16;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic [N-1:0]   req_pulse;
  logic [N*W-1:0] req_data;
  logic           tx_busy;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic [1:0]     grant_id;
  logic [N-1:0]   pend;
  logic [N-1:0]   ovf;
  logic           hs_err;
  logic           err_clr;

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;

  int         log_cyc[$];
  int         log_id[$];
  logic [7:0] log_dat[$];

  int tx_dly = 2, tx_len = 10;
  bit tx_en = 1'b1, tx_rand = 1'b0;

  uart_tx_req_sched #(.N_REQ(N), .DATA_W(W), .BUSY_TO(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_pulse(req_pulse),
    .req_data(req_data), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .grant_id(grant_id), .pend(pend), .ovf(ovf),
    .hs_err(hs_err), .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (sys_rst_n && tx_start === 1'b1) begin
      log_cyc.push_back(cyc);
      log_id.push_back(int'(grant_id));
      log_dat.push_back(tx_data);
    end
  end

  // UART TX stand-in: busy rises tx_dly cycles after the start strobe and lasts tx_len cycles.
  initial begin
    int d, l;
    tx_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_start === 1'b1 && tx_en) begin
        d = tx_rand ? int'($urandom_range(1, 20)) : tx_dly;
        l = tx_rand ? int'($urandom_range(1, 6)) : tx_len;
        repeat (d) @(posedge sys_clk);
        #1 tx_busy = 1'b1;
        repeat (l) @(posedge sys_clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    sys_rst_n = 1'b0; req_pulse = '0; err_clr = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    log_cyc.delete(); log_id.delete(); log_dat.delete();
  endtask

  task automatic pulse(input logic [N-1:0] m, output int c);
    @(posedge sys_clk); #1 req_pulse = m; c = cyc;
    @(posedge sys_clk); #1 req_pulse = '0;
  endtask

  task automatic wait_starts(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge sys_clk);
      if (log_cyc.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge sys_clk); #1; end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1; req_pulse = '0; err_clr = 1'b0; req_data = '0;
    #2 sys_rst_n = 1'b0;
    #1;
    nvec++; if (tx_start !== 1'b0) begin nbad++; $display("FAIL rst_tx_start got=%b want=0", tx_start); end
    nvec++; if (tx_data !== 8'h00) begin nbad++; $display("FAIL rst_tx_data got=%h want=00", tx_data); end
    nvec++; if (grant_id !== 2'd3) begin nbad++; $display("FAIL rst_grant_id got=%0d want=3", grant_id); end
    nvec++; if (pend !== 4'b0000) begin nbad++; $display("FAIL rst_pend got=%b want=0000", pend); end
    nvec++; if (ovf !== 4'b0000) begin nbad++; $display("FAIL rst_ovf got=%b want=0000", ovf); end
    nvec++; if (hs_err !== 1'b0) begin nbad++; $display("FAIL rst_hs_err got=%b want=0", hs_err); end
    do_reset();
  endtask

  task automatic test_single();
    int c;
    do_reset();
    tx_dly = 2; tx_len = 10; tx_en = 1'b1;
    req_data = {8'hA3, 8'h41, 8'h5C, 8'h17};
    pulse(4'b0100, c);
    repeat (30) @(posedge sys_clk);
    @(negedge sys_clk);
    nvec++; if (log_cyc.size() !== 1) begin nbad++; $display("FAIL single_count got=%0d want=1", log_cyc.size()); end
    if (log_cyc.size() >= 1) begin
      nvec++; if (log_cyc[0] !== c + 2) begin nbad++; $display("FAIL single_latency got=%0d want=%0d", log_cyc[0], c + 2); end
      nvec++; if (log_id[0] !== 2) begin nbad++; $display("FAIL single_id got=%0d want=2", log_id[0]); end
      nvec++; if (log_dat[0] !== 8'h41) begin nbad++; $display("FAIL single_data got=%h want=41", log_dat[0]); end
    end
    nvec++; if (pend !== 4'b0000) begin nbad++; $display("FAIL single_pend got=%b want=0000", pend); end
  endtask

  task automatic test_multi();
    int c;
    bit ok;
    int exp_id[3] = '{0, 1, 3};
    logic [7:0] exp_dat[3] = '{8'hC0, 8'hC1, 8'hC3};
    do_reset();
    tx_dly = 1; tx_len = 8;
    req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    pulse(4'b1011, c);
    wait_starts(3, 200, ok);
    nvec++; if (!ok) begin nbad++; $display("FAIL multi_timeout got=%0d starts want=3", log_cyc.size()); end
    if (ok) begin
      for (int k = 0; k < 3; k++) begin
        nvec++; if (log_id[k] !== exp_id[k]) begin nbad++; $display("FAIL multi_id[%0d] got=%0d want=%0d", k, log_id[k], exp_id[k]); end
        nvec++; if (log_dat[k] !== exp_dat[k]) begin nbad++; $display("FAIL multi_data[%0d] got=%h want=%h", k, log_dat[k], exp_dat[k]); end
        if (k > 0) begin
          nvec++;
          if (log_cyc[k] - log_cyc[k-1] < tx_len + 3) begin
            nbad++; $display("FAIL multi_gap[%0d] got=%0d want>=%0d", k, log_cyc[k] - log_cyc[k-1], tx_len + 3);
          end
        end
      end
    end
    repeat (20) @(posedge sys_clk);
  endtask

  task automatic test_fair();
    int c, seen;
    do_reset();
    tx_dly = 1; tx_len = 3;
    req_data = $urandom;
    pulse(4'b0011, c);
    seen = 0;
    for (int i = 0; i < 400 && log_cyc.size() < 8; i++) begin
      @(posedge sys_clk); #1;
      req_pulse = '0;
      if (log_cyc.size() > seen) begin
        req_pulse[log_id[seen]] = 1'b1;
        seen++;
      end
    end
    @(posedge sys_clk); #1 req_pulse = '0;
    nvec++; if (log_cyc.size() < 8) begin nbad++; $display("FAIL fair_count got=%0d want>=8", log_cyc.size()); end
    for (int k = 0; k < 8 && k < log_cyc.size(); k++) begin
      nvec++; if (log_id[k] !== k % 2) begin nbad++; $display("FAIL fair_id[%0d] got=%0d want=%0d", k, log_id[k], k % 2); end
      if (k > 0) begin
        nvec++; if (log_id[k] === log_id[k-1]) begin nbad++; $display("FAIL fair_repeat[%0d] got=%0d want!=%0d", k, log_id[k], log_id[k-1]); end
      end
    end
    repeat (30) @(posedge sys_clk);
  endtask

  task automatic test_ovf();
    int c, c2;
    bit ok;
    do_reset();
    tx_dly = 1; tx_len = 12;
    req_data = $urandom;
    pulse(4'b1000, c);
    pulse(4'b1000, c2);
    pulse(4'b1000, c2);
    wait_starts(2, 200, ok);
    repeat (40) @(posedge sys_clk);
    @(negedge sys_clk);
    nvec++; if (log_cyc.size() !== 2) begin nbad++; $display("FAIL ovf_starts got=%0d want=2", log_cyc.size()); end
    nvec++; if (ovf !== 4'b1000) begin nbad++; $display("FAIL ovf_flag got=%b want=1000", ovf); end
    nvec++; if (pend !== 4'b0000) begin nbad++; $display("FAIL ovf_pend got=%b want=0000", pend); end
    @(posedge sys_clk); #1 err_clr = 1'b1;
    @(posedge sys_clk); #1 err_clr = 1'b0;
    @(negedge sys_clk);
    nvec++; if (ovf !== 4'b0000) begin nbad++; $display("FAIL ovf_clear got=%b want=0000", ovf); end
  endtask

  task automatic test_timeout();
    int c, c2;
    bit ok;
    do_reset();
    tx_dly = 2; tx_len = 5; tx_en = 1'b0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    pulse(4'b0010, c);
    pulse(4'b0100, c2);
    wait_cyc(c + 17);
    @(negedge sys_clk);
    nvec++; if (hs_err !== 1'b0) begin nbad++; $display("FAIL to_early got=%b want=0", hs_err); end
    tx_en = 1'b1;
    @(negedge sys_clk);
    nvec++; if (hs_err !== 1'b1) begin nbad++; $display("FAIL to_flag got=%b want=1", hs_err); end
    wait_starts(2, 60, ok);
    nvec++; if (!ok) begin nbad++; $display("FAIL to_next got=%0d starts want=2", log_cyc.size()); end
    if (ok) begin
      nvec++; if (log_id[1] !== 2) begin nbad++; $display("FAIL to_next_id got=%0d want=2", log_id[1]); end
      nvec++; if (log_cyc[1] !== c + 19) begin nbad++; $display("FAIL to_next_cyc got=%0d want=%0d", log_cyc[1], c + 19); end
      nvec++; if (log_dat[1] !== 8'h33) begin nbad++; $display("FAIL to_next_data got=%h want=33", log_dat[1]); end
    end
    repeat (20) @(posedge sys_clk);
    @(negedge sys_clk);
    nvec++; if (hs_err !== 1'b1) begin nbad++; $display("FAIL to_sticky got=%b want=1", hs_err); end
    @(posedge sys_clk); #1 err_clr = 1'b1;
    @(posedge sys_clk); #1 err_clr = 1'b0;
    @(negedge sys_clk);
    nvec++; if (hs_err !== 1'b0) begin nbad++; $display("FAIL to_clear got=%b want=0", hs_err); end
  endtask

  task automatic test_rst_mid();
    int c, c2;
    bit ok;
    do_reset();
    tx_dly = 1; tx_len = 10;
    req_data = $urandom;
    pulse(4'b0001, c);
    pulse(4'b1010, c2);
    wait_cyc(c + 6);
    nvec++; if (pend !== 4'b1010) begin nbad++; $display("FAIL rmid_pre_pend got=%b want=1010", pend); end
    #3 sys_rst_n = 1'b0;
    #1;
    nvec++; if (tx_data !== 8'h00) begin nbad++; $display("FAIL rmid_tx_data got=%h want=00", tx_data); end
    nvec++; if (grant_id !== 2'd3) begin nbad++; $display("FAIL rmid_grant_id got=%0d want=3", grant_id); end
    nvec++; if (pend !== 4'b0000) begin nbad++; $display("FAIL rmid_pend got=%b want=0000", pend); end
    nvec++; if (tx_start !== 1'b0 || ovf !== 4'b0000 || hs_err !== 1'b0) begin
      nbad++; $display("FAIL rmid_flags got=%b/%b/%b want=0/0000/0", tx_start, ovf, hs_err);
    end
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    log_cyc.delete(); log_id.delete(); log_dat.delete();
    repeat (30) @(posedge sys_clk);
    @(negedge sys_clk);
    nvec++; if (log_cyc.size() !== 0) begin nbad++; $display("FAIL rmid_replay got=%0d starts want=0", log_cyc.size()); end
    pulse(4'b0100, c);
    wait_starts(1, 40, ok);
    nvec++; if (!ok || log_id[0] !== 2) begin nbad++; $display("FAIL rmid_new got=%0d starts want=1 (id 2)", log_cyc.size()); end
    repeat (20) @(posedge sys_clk);
  endtask

  // Reference: phase 0 = free, 1 = awaiting busy, 2 = awaiting busy fall.
  task automatic test_random();
    int ph, age, sel, mg;
    logic [N-1:0] mp, mo, g;
    logic [N*W-1:0] dat;
    logic [7:0] md;
    logic mh, es, hs_set;
    do_reset();
    tx_rand = 1'b1; tx_en = 1'b1;
    mp = '0; mo = '0; mh = 1'b0; es = 1'b0; mg = N - 1; md = '0; ph = 0; age = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge sys_clk); #1;
      for (int b = 0; b < N; b++) req_pulse[b] = ($urandom_range(0, 7) == 0);
      req_data = $urandom;
      err_clr  = ($urandom_range(0, 31) == 0);
      @(negedge sys_clk);
      nvec++; if (tx_start !== es) begin nbad++; $display("FAIL rnd_start n=%0d got=%b want=%b", n, tx_start, es); end
      nvec++; if (pend !== mp) begin nbad++; $display("FAIL rnd_pend n=%0d got=%b want=%b", n, pend, mp); end
      nvec++; if (ovf !== mo) begin nbad++; $display("FAIL rnd_ovf n=%0d got=%b want=%b", n, ovf, mo); end
      nvec++; if (hs_err !== mh) begin nbad++; $display("FAIL rnd_hs_err n=%0d got=%b want=%b", n, hs_err, mh); end
      nvec++; if (grant_id !== 2'(mg)) begin nbad++; $display("FAIL rnd_grant_id n=%0d got=%0d want=%0d", n, grant_id, mg); end
      nvec++; if (tx_data !== md) begin nbad++; $display("FAIL rnd_tx_data n=%0d got=%h want=%h", n, tx_data, md); end
      g = '0; es = 1'b0; hs_set = 1'b0;
      case (ph)
        0: if (mp != '0 && !tx_busy) begin
             sel = -1;
             for (int k = 1; k <= N; k++)
               if (sel < 0 && mp[(mg + k) % N]) sel = (mg + k) % N;
             g[sel] = 1'b1; es = 1'b1; mg = sel;
             dat = req_data; md = dat[sel*W +: W];
             ph = 1; age = 0;
           end
        1: begin
             age++;
             if (tx_busy) ph = 2;
             else if (age == TO) begin hs_set = 1'b1; ph = 0; end
           end
        default: if (!tx_busy) ph = 0;
      endcase
      mo = (err_clr ? '0 : mo) | (req_pulse & mp & ~g);
      mp = (mp & ~g) | req_pulse;
      mh = (err_clr ? 1'b0 : mh) | hs_set;
    end
    @(posedge sys_clk); #1 req_pulse = '0; err_clr = 1'b0;
    tx_rand = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_fair();
    test_ovf();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
